// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port data RAM between two requesters.
//   Requester m0 (CPU data port) and m1 (loader/debug/DMA) use a req/gnt handshake.
//   Ties are broken round-robin; the RAM is held for RAM_LATENCY cycles per access.
//   Each access returns one rvalid pulse, to its owner only.
// Ports:
//   i_clk, i_rst                      clock (rising edge), async active-high reset
//   i_mX_req/we/addr/wdata            request, write enable, address, write data (X = 0, 1)
//   o_mX_gnt                          combinational accept strobe
//   o_mX_rvalid, o_mX_rdata           completion pulse and read data (shared data register)
//   o_ram_addr/wdata/we, i_ram_rdata  RAM interface
//   o_busy                            high while an access is in progress
module data_mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_we,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_busy
);

  localparam int unsigned CNT_W = $clog2(RAM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_LATENCY);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_owner;       // 0 = m0, 1 = m1
  logic                r_last_grant;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_m0_rvalid;
  logic                r_m1_rvalid;

  logic                w_idle;
  logic                w_sel;
  logic                w_any_gnt;
  logic                w_cnt_done;

  // Requester selection: a lone request wins; on a tie the one not granted last time wins.
  always_comb begin
    w_sel = 1'b0;
    if (i_m0_req && i_m1_req) begin
      w_sel = ~r_last_grant;
    end else if (i_m1_req) begin
      w_sel = 1'b1;
    end
  end

  assign w_idle     = (r_state == StIdle);
  assign o_m0_gnt   = i_m0_req & ~w_sel & w_idle & ~i_rst;
  assign o_m1_gnt   = i_m1_req &  w_sel & w_idle & ~i_rst;
  assign w_any_gnt  = o_m0_gnt | o_m1_gnt;
  assign w_cnt_done = (r_cnt == CNT_LAST);

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_any_gnt)  w_state_next = StAccess;
      StAccess: if (w_cnt_done) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Request latch, latency counter and completion
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt        <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_m0_rvalid  <= 1'b0;
      r_m1_rvalid  <= 1'b0;
    end else begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      if (w_any_gnt) begin
        r_owner      <= w_sel;
        r_last_grant <= w_sel;
        r_we         <= w_sel ? i_m1_we    : i_m0_we;
        r_addr       <= w_sel ? i_m1_addr  : i_m0_addr;
        r_wdata      <= w_sel ? i_m1_wdata : i_m0_wdata;
        r_cnt        <= CNT_ONE;
      end else if (r_state == StAccess) begin
        if (w_cnt_done) begin
          if (!r_we) begin
            r_rdata <= i_ram_rdata;
          end
          r_m0_rvalid <= ~r_owner;
          r_m1_rvalid <= r_owner;
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end
    end
  end

  // Write strobe only in the first access cycle so each write hits the RAM once.
  assign o_ram_we    = (r_state == StAccess) && r_we && (r_cnt == CNT_ONE);
  assign o_ram_addr  = r_addr;
  assign o_ram_wdata = r_wdata;
  assign o_busy      = ~w_idle;
  assign o_m0_rvalid = r_m0_rvalid;
  assign o_m1_rvalid = r_m1_rvalid;
  assign o_m0_rdata  = r_rdata;
  assign o_m1_rdata  = r_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---------------- DUT 1: RAM_LATENCY = 1 ----------------
  logic        m0_req1, m0_we1, m1_req1, m1_we1;
  logic [31:0] m0_addr1, m0_wdata1, m1_addr1, m1_wdata1;
  logic        m0_gnt1, m0_rvalid1, m1_gnt1, m1_rvalid1, ram_we1, busy1;
  logic [31:0] m0_rdata1, m1_rdata1, ram_addr1, ram_wdata1, ram_rdata1;
  logic [31:0] mem1 [0:255];

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req1), .i_m0_we(m0_we1), .i_m0_addr(m0_addr1), .i_m0_wdata(m0_wdata1),
    .o_m0_gnt(m0_gnt1), .o_m0_rvalid(m0_rvalid1), .o_m0_rdata(m0_rdata1),
    .i_m1_req(m1_req1), .i_m1_we(m1_we1), .i_m1_addr(m1_addr1), .i_m1_wdata(m1_wdata1),
    .o_m1_gnt(m1_gnt1), .o_m1_rvalid(m1_rvalid1), .o_m1_rdata(m1_rdata1),
    .o_ram_addr(ram_addr1), .o_ram_wdata(ram_wdata1), .o_ram_we(ram_we1),
    .i_ram_rdata(ram_rdata1), .o_busy(busy1)
  );

  assign ram_rdata1 = mem1[ram_addr1[7:0]];
  always @(posedge clk) if (ram_we1) mem1[ram_addr1[7:0]] <= ram_wdata1;

  // ---------------- DUT 2: RAM_LATENCY = 3 ----------------
  logic        m0_req2;
  logic [31:0] m0_addr2;
  logic        m0_gnt2, m0_rvalid2, m1_gnt2, m1_rvalid2, ram_we2, busy2;
  logic [31:0] m0_rdata2, m1_rdata2, ram_addr2, ram_wdata2, ram_rdata2;
  logic [31:0] mem2 [0:255];

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(3)) u_dut2 (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req2), .i_m0_we(1'b0), .i_m0_addr(m0_addr2), .i_m0_wdata(32'h0),
    .o_m0_gnt(m0_gnt2), .o_m0_rvalid(m0_rvalid2), .o_m0_rdata(m0_rdata2),
    .i_m1_req(1'b0), .i_m1_we(1'b0), .i_m1_addr(32'h0), .i_m1_wdata(32'h0),
    .o_m1_gnt(m1_gnt2), .o_m1_rvalid(m1_rvalid2), .o_m1_rdata(m1_rdata2),
    .o_ram_addr(ram_addr2), .o_ram_wdata(ram_wdata2), .o_ram_we(ram_we2),
    .i_ram_rdata(ram_rdata2), .o_busy(busy2)
  );

  assign ram_rdata2 = mem2[ram_addr2[7:0]];
  always @(posedge clk) if (ram_we2) mem2[ram_addr2[7:0]] <= ram_wdata2;

  // ---------------- Scoreboard for DUT 1 ----------------
  typedef struct {
    logic        owner;
    logic        hold;   // write: rdata keeps its previous value
    logic [31:0] data;
    int          due;
  } sb_t;

  sb_t         q[$];
  sb_t         e_pop;
  sb_t         e_push;
  logic [31:0] shadow [0:255];
  logic [31:0] model_rdata = 32'h0;
  logic [31:0] exp_data;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      model_rdata = 32'h0;
    end else begin
      if (m0_rvalid1 || m1_rvalid1) begin
        if (m0_rvalid1 && m1_rvalid1) chk("sb_both_rvalid", 32'd1, 32'd0);
        if (q.size() == 0) begin
          chk("sb_unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          e_pop = q.pop_front();
          exp_data = e_pop.hold ? model_rdata : e_pop.data;
          model_rdata = exp_data;
          chk("sb_owner", {31'd0, m1_rvalid1}, {31'd0, e_pop.owner});
          chk("sb_latency", cyc, e_pop.due);
          chk("sb_rdata", m1_rvalid1 ? m1_rdata1 : m0_rdata1, exp_data);
        end
      end
      if (m0_gnt1 || m1_gnt1) begin
        e_push.owner = m1_gnt1;
        e_push.due   = cyc + 2;
        if (m1_gnt1) begin
          e_push.hold = m1_we1;
          e_push.data = shadow[m1_addr1[7:0]];
          if (m1_we1) shadow[m1_addr1[7:0]] = m1_wdata1;
        end else begin
          e_push.hold = m0_we1;
          e_push.data = shadow[m0_addr1[7:0]];
          if (m0_we1) shadow[m0_addr1[7:0]] = m0_wdata1;
        end
        q.push_back(e_push);
      end
    end
  end

  // ---------------- Vector table for DUT 1 ----------------
  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        g0, g1, bz, we, v0, v1;
    logic [31:0] ra;     // expected ram_addr, checked while busy
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(
    input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
    input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
    input logic g0, input logic g1, input logic bz, input logic we,
    input logic v0, input logic v1, input logic [31:0] ra);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.bz = bz; v.we = we; v.v0 = v0; v.v1 = v1; v.ra = ra;
    return v;
  endfunction

  task automatic drive1(input logic r0, input logic w0, input logic [31:0] a0,
                        input logic [31:0] d0, input logic r1, input logic w1,
                        input logic [31:0] a1, input logic [31:0] d1);
    m0_req1 = r0; m0_we1 = w0; m0_addr1 = a0; m0_wdata1 = d0;
    m1_req1 = r1; m1_we1 = w1; m1_addr1 = a1; m1_wdata1 = d1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'h0; mem2[i] = 32'h0; shadow[i] = 32'h0;
    end
    mem1[8'h10] = 32'hDEADBEEF; shadow[8'h10] = 32'hDEADBEEF;
    mem1[8'h14] = 32'hCAFEF00D; shadow[8'h14] = 32'hCAFEF00D;
    mem1[8'h30] = 32'h0BADF00D; shadow[8'h30] = 32'h0BADF00D;
    mem2[8'h10] = 32'h11223344;

    //            r0 w0 a0     d0  r1 w1 a1     d1            g0 g1 bz we v0 v1 ra
    vecs[0]  = mk(1, 0, 32'h10, 0, 1, 0, 32'h14, 0,            1, 0, 0, 0, 0, 0, 32'h0);
    vecs[1]  = mk(1, 0, 32'h10, 0, 1, 0, 32'h14, 0,            0, 0, 1, 0, 0, 0, 32'h10);
    vecs[2]  = mk(1, 0, 32'h10, 0, 1, 0, 32'h14, 0,            0, 1, 0, 0, 1, 0, 32'h0);
    vecs[3]  = mk(1, 0, 32'h10, 0, 1, 0, 32'h14, 0,            0, 0, 1, 0, 0, 0, 32'h14);
    vecs[4]  = mk(1, 0, 32'h10, 0, 1, 0, 32'h14, 0,            1, 0, 0, 0, 0, 1, 32'h0);
    vecs[5]  = mk(1, 0, 32'h10, 0, 1, 0, 32'h14, 0,            0, 0, 1, 0, 0, 0, 32'h10);
    vecs[6]  = mk(1, 0, 32'h10, 0, 1, 0, 32'h14, 0,            0, 1, 0, 0, 1, 0, 32'h0);
    vecs[7]  = mk(0, 0, 32'h0,  0, 1, 1, 32'h20, 32'h12345678, 0, 0, 1, 0, 0, 0, 32'h14);
    vecs[8]  = mk(0, 0, 32'h0,  0, 1, 1, 32'h20, 32'h12345678, 0, 1, 0, 0, 0, 1, 32'h0);
    vecs[9]  = mk(1, 0, 32'h20, 0, 0, 0, 32'h0,  0,            0, 0, 1, 1, 0, 0, 32'h20);
    vecs[10] = mk(1, 0, 32'h20, 0, 0, 0, 32'h0,  0,            1, 0, 0, 0, 0, 1, 32'h0);
    vecs[11] = mk(0, 0, 32'h0,  0, 0, 0, 32'h0,  0,            0, 0, 1, 0, 0, 0, 32'h20);
    vecs[12] = mk(0, 0, 32'h0,  0, 0, 0, 32'h0,  0,            0, 0, 0, 0, 1, 0, 32'h0);
    vecs[13] = mk(1, 0, 32'h10, 0, 0, 0, 32'h0,  0,            1, 0, 0, 0, 0, 0, 32'h0);
    // m1 requests during m0's access and withdraws before idle: no grant, no access.
    vecs[14] = mk(0, 0, 32'h0,  0, 1, 0, 32'h30, 0,            0, 0, 1, 0, 0, 0, 32'h10);
    vecs[15] = mk(0, 0, 32'h0,  0, 0, 0, 32'h0,  0,            0, 0, 0, 0, 1, 0, 32'h0);
    vecs[16] = mk(0, 0, 32'h0,  0, 0, 0, 32'h0,  0,            0, 0, 0, 0, 0, 0, 32'h0);

    drive1(0, 0, 0, 0, 0, 0, 0, 0);
    m0_req2 = 1'b0; m0_addr2 = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", {30'd0, m0_gnt1, m1_gnt1}, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we1}, 32'd0);
    chk("rst_rvalid", {30'd0, m0_rvalid1, m1_rvalid1}, 32'd0);
    chk("rst_ram_addr", ram_addr1, 32'd0);
    chk("rst_rdata", m0_rdata1, 32'd0);
    rst = 1'b0;

    // Table: alternation, write then read-back, dropped request
    for (int i = 0; i < 17; i++) begin
      drive1(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
             vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      @(negedge clk);
      chk($sformatf("v%0d_m0_gnt", i), {31'd0, m0_gnt1}, {31'd0, vecs[i].g0});
      chk($sformatf("v%0d_m1_gnt", i), {31'd0, m1_gnt1}, {31'd0, vecs[i].g1});
      chk($sformatf("v%0d_busy", i), {31'd0, busy1}, {31'd0, vecs[i].bz});
      chk($sformatf("v%0d_ram_we", i), {31'd0, ram_we1}, {31'd0, vecs[i].we});
      chk($sformatf("v%0d_m0_rvalid", i), {31'd0, m0_rvalid1}, {31'd0, vecs[i].v0});
      chk($sformatf("v%0d_m1_rvalid", i), {31'd0, m1_rvalid1}, {31'd0, vecs[i].v1});
      if (vecs[i].bz) chk($sformatf("v%0d_ram_addr", i), ram_addr1, vecs[i].ra);
      @(posedge clk);
      #1;
    end
    chk("mem_0x20_written", mem1[8'h20], 32'h12345678);
    chk("mem_0x30_untouched", mem1[8'h30], 32'h0BADF00D);

    // Latency 3: m0 read
    m0_req2 = 1'b1; m0_addr2 = 32'h10;
    @(negedge clk);
    chk("l3_gnt", {31'd0, m0_gnt2}, 32'd1);
    @(posedge clk);
    #1;
    m0_req2 = 1'b0; m0_addr2 = 32'h0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("l3_busy_%0d", k), {31'd0, busy2}, 32'd1);
      chk($sformatf("l3_ram_we_%0d", k), {31'd0, ram_we2}, 32'd0);
      chk($sformatf("l3_rvalid_%0d", k), {31'd0, m0_rvalid2}, 32'd0);
      chk($sformatf("l3_ram_addr_%0d", k), ram_addr2, 32'h10);
    end
    @(negedge clk);
    chk("l3_rvalid", {30'd0, m0_rvalid2, m1_rvalid2}, 32'd2);
    chk("l3_rdata", m0_rdata2, 32'h11223344);
    chk("l3_busy_done", {31'd0, busy2}, 32'd0);
    @(negedge clk);
    chk("l3_rvalid_pulse", {31'd0, m0_rvalid2}, 32'd0);
    @(posedge clk);
    #1;

    // Reset during m1 write access
    drive1(0, 0, 0, 0, 1, 1, 32'h40, 32'hAAAA5555);
    @(negedge clk);
    chk("abort_gnt", {31'd0, m1_gnt1}, 32'd1);
    @(posedge clk);
    #1;
    chk("abort_ram_we_pre", {31'd0, ram_we1}, 32'd1);
    drive1(1, 0, 32'h10, 0, 1, 1, 32'h40, 32'hAAAA5555);
    rst = 1'b1;
    #1;
    chk("abort_ram_we", {31'd0, ram_we1}, 32'd0);
    chk("abort_busy", {31'd0, busy1}, 32'd0);
    chk("abort_gnt_forced", {30'd0, m0_gnt1, m1_gnt1}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("abort_rvalid_%0d", k), {30'd0, m0_rvalid1, m1_rvalid1}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive1(1, 0, 32'h10, 0, 1, 0, 32'h14, 0);
    @(negedge clk);
    chk("post_rst_gnt", {30'd0, m0_gnt1, m1_gnt1}, 32'd2);
    @(posedge clk);
    #1;
    drive1(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_write", mem1[8'h40], 32'h0);
    chk("sb_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
